// File: rtl/flag_cond_unit.sv
// -----------------------------------------------------------------------------
// flag_cond_unit
//
// Holds the ALU flags (N, Z, C, V) in a register and evaluates condition-code
// requests against them through a single-outstanding valid/ready handshake.
// A request that arrives while no valid flags are held parks in WAIT until
// the next flag write. The result is produced one cycle after acceptance
// (EVAL) and held in RESP until the consumer takes it. Responses that
// evaluate true are counted in a saturating 8-bit counter.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   flags_in    [3:0] ALU flags, {N, Z, C, V}
//   flags_we    capture flags_in at the rising edge (wins over flags_inv)
//   flags_inv   invalidate the held flags at the rising edge
//   cond_valid  condition request present
//   cond_code   [3:0] condition code to evaluate
//   cond_ready  block can accept a request (only in IDLE)
//   resp_valid  response valid (only in RESP)
//   resp_ready  consumer accepts the response
//   resp_taken  evaluated condition result
//   flags_q     [3:0] held flags register
//   flags_ok    flags_q holds valid flags
//   taken_cnt   [7:0] saturating count of true responses
// -----------------------------------------------------------------------------
module flag_cond_unit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] flags_in,
    input  logic       flags_we,
    input  logic       flags_inv,
    input  logic       cond_valid,
    input  logic [3:0] cond_code,
    output logic       cond_ready,
    output logic       resp_valid,
    input  logic       resp_ready,
    output logic       resp_taken,
    output logic [3:0] flags_q,
    output logic       flags_ok,
    output logic [7:0] taken_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_EVAL = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // Condition evaluation over the flag vector {N, Z, C, V}.
    function automatic logic cond_eval(input logic [3:0] code, input logic [3:0] flg);
        logic n_f;
        logic z_f;
        logic c_f;
        logic v_f;
        logic res;
        n_f = flg[3];
        z_f = flg[2];
        c_f = flg[1];
        v_f = flg[0];
        case (code)
            4'd0:    res = z_f;
            4'd1:    res = ~z_f;
            4'd2:    res = c_f;
            4'd3:    res = ~c_f;
            4'd4:    res = n_f;
            4'd5:    res = ~n_f;
            4'd6:    res = v_f;
            4'd7:    res = ~v_f;
            4'd8:    res = c_f & ~z_f;
            4'd9:    res = ~c_f | z_f;
            4'd10:   res = (n_f == v_f);
            4'd11:   res = (n_f != v_f);
            4'd12:   res = ~z_f & (n_f == v_f);
            4'd13:   res = z_f | (n_f != v_f);
            4'd14:   res = 1'b1;
            4'd15:   res = 1'b0;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    state_t     state_r;
    state_t     state_next_s;
    logic       accept_s;
    logic       eval_s;
    logic       eval_hit_s;
    logic       cnt_sat_s;

    logic [3:0] code_r;
    logic [3:0] flags_q_r;
    logic       flags_ok_r;
    logic       resp_valid_r;
    logic       resp_taken_r;
    logic [7:0] taken_cnt_r;

    // Evaluation reads the registered flags, so a write landing on the EVAL
    // edge or later cannot disturb the result already being produced.
    assign eval_s     = (state_r == ST_EVAL);
    assign eval_hit_s = cond_eval(code_r, flags_q_r);
    assign cnt_sat_s  = (taken_cnt_r == 8'hFF);

    // Next-state logic and request acceptance.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cond_valid) begin
                    accept_s = 1'b1;
                    // A flag write in the accept cycle makes flags valid for EVAL.
                    if (flags_ok_r || flags_we) begin
                        state_next_s = ST_EVAL;
                    end else begin
                        state_next_s = ST_WAIT;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // Invalidation here is irrelevant: only a fresh write releases us.
                if (flags_we) begin
                    state_next_s = ST_EVAL;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_EVAL: begin
                state_next_s = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RESP;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Latch the condition code only on acceptance; later changes are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_r <= 4'd0;
        end else if (accept_s) begin
            code_r <= cond_code;
        end else begin
            code_r <= code_r;
        end
    end

    // Flag register: write wins over invalidate, runs in every FSM state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q_r  <= 4'b0000;
            flags_ok_r <= 1'b0;
        end else if (flags_we) begin
            flags_q_r  <= flags_in;
            flags_ok_r <= 1'b1;
        end else if (flags_inv) begin
            flags_q_r  <= flags_q_r;
            flags_ok_r <= 1'b0;
        end else begin
            flags_q_r  <= flags_q_r;
            flags_ok_r <= flags_ok_r;
        end
    end

    // Response valid tracks entry into / exit from RESP as a registered flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid_r <= 1'b0;
        end else begin
            resp_valid_r <= (state_next_s == ST_RESP);
        end
    end

    // Result is captured once in EVAL and held until the next evaluation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_taken_r <= 1'b0;
        end else if (eval_s) begin
            resp_taken_r <= eval_hit_s;
        end else begin
            resp_taken_r <= resp_taken_r;
        end
    end

    // Saturating count of true evaluations; sticks at 255.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken_cnt_r <= 8'd0;
        end else if (eval_s && eval_hit_s && !cnt_sat_s) begin
            taken_cnt_r <= taken_cnt_r + 8'd1;
        end else begin
            taken_cnt_r <= taken_cnt_r;
        end
    end

    // cond_ready is a pure decode of IDLE so it reads 1 during reset.
    assign cond_ready = (state_r == ST_IDLE);
    assign resp_valid = resp_valid_r;
    assign resp_taken = resp_taken_r;
    assign flags_q    = flags_q_r;
    assign flags_ok   = flags_ok_r;
    assign taken_cnt  = taken_cnt_r;

endmodule
